dtim_wb_cache: RTL and testbench
================================

// Module: dtim_wb_cache
// PURPOSE
//  Parametrised write-back data TIM/cache between the core data port and the data memory bus.
//  Direct-mapped, 2**DEPTH sets x 2**WIDTH words; tracks per-line valid+dirty, evicts only dirty victims.
//  Fence flushes dirty lines (optionally invalidates). Addresses outside [BASE_ADDR,TOP_ADDR) bypass to memory.
// PARAMETERS
//  DEPTH      6             log2 number of sets; index = addr[DEPTH+WIDTH+1:WIDTH+2]
//  WIDTH      2             log2 words per line (0..3); word = addr[WIDTH+1:2]; tag = addr[31:DEPTH+WIDTH+2]
//  BASE_ADDR  32'h0000_0000 first cacheable byte address
//  TOP_ADDR   32'h0010_0000 first non-cacheable byte address above the region
//  FENCE_INV  0             1: fence also clears valid of every set; 0: fence cleans only (valid kept)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  req_valid    in   1   one-cycle request pulse from core
//  req_fence    in   1   request is a fence (addr/data ignored)
//  req_addr     in   32  byte address, word aligned
//  req_wdata    in   32  store data
//  req_wstrb    in   4   byte strobes; 0 = load
//  rsp_ready    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  load data (0 for fence; merged word for stores)
//  mem_valid    out  1   memory request, held until mem_ready
//  mem_addr     out  32  memory word address
//  mem_wdata    out  32  memory write data
//  mem_wstrb    out  4   memory strobes; 0 = read
//  mem_fence    out  1   tied 0
//  mem_instr    out  1   tied 0
//  mem_rdata    in   32  memory read data, valid with mem_ready
//  mem_ready    in   1   memory completion for current beat
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, all valid/dirty bits 0, cnt=0; rsp_ready=0, rsp_rdata=0, mem_valid=0,
//   mem_addr=0, mem_wdata=0, mem_wstrb=0. Tag/data arrays not reset. Mid-burst reset aborts; dirty data lost.
//  One outstanding request: req_valid accepted only in IDLE; pulses in other states are ignored (illegal).
//  Arrays: synchronous read, read issued in acceptance cycle T; lookup/compare in T+1.
//  mem_* outputs registered; stable while mem_valid=1 and mem_ready=0; each beat ends on mem_ready=1.
//  States: IDLE, LOOKUP, EVICT, FILL, UPDATE, BYPASS, FL_READ, FL_WB, FL_DONE.
//  LOOKUP (T+1):
//   - addr outside region -> BYPASS: one beat with req addr/wdata/wstrb; rsp_ready=mem_ready, rsp_rdata=mem_rdata
//     in the same cycle; -> IDLE.
//   - hit (valid & tag match), load -> rsp_ready=1 at T+1 with word; -> IDLE. No mem traffic.
//   - hit, store -> strobe-merge word, write line at T+1, dirty=1, rsp_ready=1 at T+1, rsp_rdata=merged; -> IDLE.
//   - miss, victim invalid or clean -> FILL. miss, victim valid & dirty -> EVICT.
//  EVICT: 2**WIDTH write beats to {victim_tag,index,cnt,2'b00}, wstrb=4'hF, cnt 0..2**WIDTH-1; after last -> FILL.
//  FILL: 2**WIDTH read beats from {req_tag,index,cnt,2'b00}; beat cnt stored to word cnt. After last beat
//   write line (store merged), tag, valid=1, dirty=store; -> UPDATE.
//  UPDATE: rsp_ready=1, rsp_rdata=requested word (merged for store); -> IDLE.
//  Fence: FL_READ reads set idx (starts 0); next cycle if valid&dirty -> FL_WB (line write-back as EVICT),
//   then dirty=0 (valid=0 if FENCE_INV). Clean set: update bits, idx+1. After idx=2**DEPTH-1 -> FL_DONE:
//   rsp_ready=1, rsp_rdata=0; -> IDLE. Fence with no dirty lines: 2**DEPTH+1 cycles, zero mem traffic.
//  cnt is max(WIDTH,1) bits, wraps to 0 after last beat; idx wraps to 0 after flush. WIDTH=0: single-beat lines.
//  rsp_ready is 0 in all cycles not listed; rsp_rdata holds last value when rsp_ready=0.
// TESTING  (bench: DEPTH=2, WIDTH=1, BASE=0, TOP=0x1000, FENCE_INV=0)
//  Cold load 0x100, mem returns 0x11111111/0x22222222 -> reads 0x100,0x104; rsp 0x11111111; load 0x104 -> rsp T+1 0x22222222, no mem_valid.
//  Store 0x104 wstrb=0x3 wdata=0xAAAA5555 (hit) -> rsp T+1, no mem traffic; load 0x104 -> 0x22225555.
//  Load 0x120 (same index 0, new tag) -> writes 0x100=0x11111111, 0x104=0x22225555 wstrb F, then reads 0x120,0x124.
//  Load 0x2000 -> single beat addr 0x2000 wstrb 0, rsp_ready same cycle as mem_ready; store wstrb 0x4 forwarded unchanged.
//  Dirty line in set 1 then fence -> exactly 2 write beats, rsp_ready rdata 0; second fence -> 5 cycles, no mem_valid.
//  rst low after first FILL beat -> mem_valid 0 immediately; after release, load same addr misses and refills 2 beats.

Source files
------------

// File: rtl/dtim_wb_cache.sv
// Direct-mapped write-back data TIM/cache between core data port and memory bus; uncached window bypasses.
// Latency: hit responds the cycle after acceptance; miss = evict beats + fill beats + 1; fence = sets + 1 + write-backs.
// Backpressure: one request in flight (req_valid ignored when busy); mem beats held stable until mem_ready.
//
// Ports:
//   clk_i, rst_i                   clock (rising edge) and asynchronous active-low reset
//   req_valid_i/fence/addr/wdata/wstrb_i   core request pulse; wstrb 0 = load
//   rsp_ready_o, rsp_rdata_o       one-cycle completion pulse and data (held while not pulsing)
//   mem_valid/addr/wdata/wstrb_o   registered memory beat, held until mem_ready_i
//   mem_fence_o, mem_instr_o       tied low
//   mem_rdata_i, mem_ready_i       memory beat completion and read data
module dtim_wb_cache #(
  parameter int unsigned DEPTH     = 6,
  parameter int unsigned WIDTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] TOP_ADDR  = 32'h0010_0000,
  parameter bit          FENCE_INV = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_fence_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_ready_o,
  output logic [31:0] rsp_rdata_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_fence_o,
  output logic        mem_instr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int unsigned SETS = 1 << DEPTH;
  localparam int unsigned WPL  = 1 << WIDTH;
  localparam int unsigned CW   = (WIDTH > 0) ? WIDTH : 1;
  localparam int unsigned OFFW = WIDTH + 2;
  localparam int unsigned TAGW = 32 - DEPTH - OFFW;

  typedef logic [WPL-1:0][31:0] line_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_UPDATE, S_BYPASS, S_FL_READ, S_FL_WB, S_FL_DONE
  } state_e;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [TAGW-1:0] tag, input logic [DEPTH-1:0] set,
                                            input logic [CW-1:0] cnt);
    return {tag, set, {OFFW{1'b0}}} | (32'(cnt) << 2);
  endfunction

  // Storage (tag/data not reset)
  line_t           data_arr [SETS];
  logic [TAGW-1:0] tag_arr  [SETS];

  state_e          state_q, state_d;
  logic [31:0]     req_addr_q, req_wdata_q;
  logic [3:0]      req_wstrb_q;
  line_t           line_q;
  logic [TAGW-1:0] tag_q;
  logic [SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nx;
  logic [DEPTH-1:0] idx_q, idx_d, idx_nx;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     rdata_hold_q;

  // Array control
  logic             cap_req, rd_en, arr_we, tag_we, line_ld;
  logic [DEPTH-1:0] rd_set;
  line_t            arr_line, line_ld_val;

  // Decode of the captured request
  logic [DEPTH-1:0] req_set;
  logic [TAGW-1:0]  req_tag;
  logic [CW-1:0]    word_sel;
  logic             in_region, hit, is_store, victim_dirty, last_beat, last_set, fl_dirty;
  logic [31:0]      merged_word;
  line_t            hit_line, fill_raw, fill_line;

  assign req_set   = DEPTH'(req_addr_q >> OFFW);
  assign req_tag   = TAGW'(req_addr_q >> (DEPTH + OFFW));
  assign word_sel  = CW'(req_addr_q >> 2) & CW'(WPL - 1);
  // Unsigned wrap makes this a single compare for [BASE,TOP)
  assign in_region = (req_addr_q - BASE_ADDR) < (TOP_ADDR - BASE_ADDR);
  assign hit       = valid_q[req_set] && (tag_q == req_tag);
  assign is_store  = |req_wstrb_q;
  assign victim_dirty = valid_q[req_set] & dirty_q[req_set];
  assign last_beat = (cnt_q == CW'(WPL - 1));
  assign last_set  = (idx_q == DEPTH'(SETS - 1));
  assign fl_dirty  = valid_q[idx_q] & dirty_q[idx_q];
  assign cnt_nx    = last_beat ? '0 : cnt_q + CW'(1);
  assign idx_nx    = idx_q + DEPTH'(1);

  assign merged_word = merge_word(line_q[word_sel], req_wdata_q, req_wstrb_q);

  always_comb begin
    hit_line           = line_q;
    hit_line[word_sel] = merged_word;
    fill_raw           = line_q;
    fill_raw[cnt_q]    = mem_rdata_i;
    fill_line          = fill_raw;
    if (is_store) fill_line[word_sel] = merge_word(fill_raw[word_sel], req_wdata_q, req_wstrb_q);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req_valid_i) state_d = req_fence_i ? S_FL_READ : S_LOOKUP;
      S_LOOKUP: begin
        if (!in_region)        state_d = S_BYPASS;
        else if (hit)          state_d = S_IDLE;
        else if (victim_dirty) state_d = S_EVICT;
        else                   state_d = S_FILL;
      end
      S_EVICT:   if (mem_ready_i && last_beat) state_d = S_FILL;
      S_FILL:    if (mem_ready_i && last_beat) state_d = S_UPDATE;
      S_UPDATE:  state_d = S_IDLE;
      S_BYPASS:  if (mem_ready_i) state_d = S_IDLE;
      S_FL_READ: begin
        if (fl_dirty)      state_d = S_FL_WB;
        else if (last_set) state_d = S_FL_DONE;
      end
      S_FL_WB:   if (mem_ready_i && last_beat) state_d = last_set ? S_FL_DONE : S_FL_READ;
      S_FL_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath control
  always_comb begin
    rsp_ready_o = 1'b0;
    rsp_rdata_o = rdata_hold_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    cap_req     = 1'b0;
    rd_en       = 1'b0;
    rd_set      = DEPTH'(req_addr_i >> OFFW);
    arr_we      = 1'b0;
    tag_we      = 1'b0;
    arr_line    = hit_line;
    line_ld     = 1'b0;
    line_ld_val = fill_raw;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cap_req = 1'b1;
          rd_en   = 1'b1;
          if (req_fence_i) rd_set = '0;
        end
      end
      S_LOOKUP: begin
        if (!in_region) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = req_addr_q;
          mem_wdata_d = req_wdata_q;
          mem_wstrb_d = req_wstrb_q;
        end else if (hit) begin
          rsp_ready_o = 1'b1;
          rsp_rdata_o = is_store ? merged_word : line_q[word_sel];
          if (is_store) begin
            arr_we           = 1'b1;
            dirty_d[req_set] = 1'b1;
          end
        end else if (victim_dirty) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = beat_addr(tag_q, req_set, '0);
          mem_wdata_d = line_q[0];
          mem_wstrb_d = 4'hF;
          cnt_d       = '0;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = beat_addr(req_tag, req_set, '0);
          mem_wdata_d = '0;
          mem_wstrb_d = 4'h0;
          cnt_d       = '0;
        end
      end
      S_EVICT: begin
        if (mem_ready_i) begin
          cnt_d = cnt_nx;
          if (last_beat) begin
            // Victim gone; first fill beat follows without dropping mem_valid
            mem_addr_d  = beat_addr(req_tag, req_set, '0);
            mem_wdata_d = '0;
            mem_wstrb_d = 4'h0;
          end else begin
            mem_addr_d  = beat_addr(tag_q, req_set, cnt_nx);
            mem_wdata_d = line_q[cnt_nx];
          end
        end
      end
      S_FILL: begin
        if (mem_ready_i) begin
          cnt_d   = cnt_nx;
          line_ld = 1'b1;
          if (last_beat) begin
            mem_valid_d      = 1'b0;
            line_ld_val      = fill_line;
            arr_we           = 1'b1;
            arr_line         = fill_line;
            tag_we           = 1'b1;
            valid_d[req_set] = 1'b1;
            dirty_d[req_set] = is_store;
          end else begin
            mem_addr_d = beat_addr(req_tag, req_set, cnt_nx);
          end
        end
      end
      S_UPDATE: begin
        rsp_ready_o = 1'b1;
        rsp_rdata_o = line_q[word_sel];
      end
      S_BYPASS: begin
        rsp_ready_o = mem_ready_i;
        if (mem_ready_i) begin
          rsp_rdata_o = mem_rdata_i;
          mem_valid_d = 1'b0;
        end
      end
      S_FL_READ: begin
        if (fl_dirty) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = beat_addr(tag_q, idx_q, '0);
          mem_wdata_d = line_q[0];
          mem_wstrb_d = 4'hF;
          cnt_d       = '0;
        end else begin
          if (FENCE_INV) valid_d[idx_q] = 1'b0;
          idx_d  = idx_nx;
          rd_en  = 1'b1;
          rd_set = idx_nx;
        end
      end
      S_FL_WB: begin
        if (mem_ready_i) begin
          cnt_d = cnt_nx;
          if (last_beat) begin
            mem_valid_d    = 1'b0;
            dirty_d[idx_q] = 1'b0;
            if (FENCE_INV) valid_d[idx_q] = 1'b0;
            idx_d  = idx_nx;
            rd_en  = 1'b1;
            rd_set = idx_nx;
          end else begin
            mem_addr_d  = beat_addr(tag_q, idx_q, cnt_nx);
            mem_wdata_d = line_q[cnt_nx];
          end
        end
      end
      S_FL_DONE: begin
        rsp_ready_o = 1'b1;
        rsp_rdata_o = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      rdata_hold_q <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if (rsp_ready_o) rdata_hold_q <= rsp_rdata_o;
      if (cap_req) begin
        req_addr_q  <= req_addr_i;
        req_wdata_q <= req_wdata_i;
        req_wstrb_q <= req_wstrb_i;
      end
    end
  end

  // Synchronous array read into line_q/tag_q; fill beats assemble the new line in line_q
  always_ff @(posedge clk_i) begin
    if (arr_we) data_arr[req_set] <= arr_line;
    if (tag_we) tag_arr[req_set]  <= req_tag;
    if (rd_en) begin
      line_q <= data_arr[rd_set];
      tag_q  <= tag_arr[rd_set];
    end else if (line_ld) begin
      line_q <= line_ld_val;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_fence_o = 1'b0;
  assign mem_instr_o = 1'b0;

endmodule

// File: tb/tb_dtim_wb_cache.sv
// Directed bench for dtim_wb_cache: scoreboard queues for responses and memory beats.
// Memory model answers every beat after one stall cycle, so held-beat behaviour is exercised.
// Every wait is bounded; timeouts count as errors.
module tb_dtim_wb_cache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_fence_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_ready_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_valid_o, mem_fence_o, mem_instr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;

  dtim_wb_cache #(
    .DEPTH(2), .WIDTH(1), .BASE_ADDR(32'h0), .TOP_ADDR(32'h1000), .FENCE_INV(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_fence_i(req_fence_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_fence_o(mem_fence_o), .mem_instr_o(mem_instr_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] rdata; int cyc; bit byp; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } beat_t;

  rsp_t  exp_rsp[$];
  beat_t exp_beat[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks = 0, errors = 0;
  int cyc = 0, rsp_cnt = 0, beat_cnt = 0, mv_cnt = 0;
  bit stall = 1'b0;
  rsp_t  mon_r;
  beat_t mon_b;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    check32(tag, {31'b0, cond}, 32'd1);
  endtask

  always @(posedge clk_i) cyc++;

  // Memory responder and output monitor
  always @(negedge clk_i) begin
    if (mem_valid_o) mv_cnt++;
    if (mem_valid_o && rst_i) begin
      if (!stall) begin
        mem_ready_i = 1'b0;
        stall = 1'b1;
      end else begin
        stall = 1'b0;
        mem_ready_i = 1'b1;
        beat_cnt++;
        mem_rdata_i = (mem_wstrb_o == 4'h0 && mem_model.exists(mem_addr_o)) ? mem_model[mem_addr_o] : 32'h0;
        check_true("beat_expected", exp_beat.size() != 0);
        if (exp_beat.size() != 0) begin
          mon_b = exp_beat.pop_front();
          check32("beat_addr", mem_addr_o, mon_b.addr);
          check32("beat_wstrb", {28'b0, mem_wstrb_o}, {28'b0, mon_b.wstrb});
          if (mon_b.wstrb != 4'h0) check32("beat_wdata", mem_wdata_o, mon_b.wdata);
        end
        if (mem_wstrb_o != 4'h0) begin
          logic [31:0] w;
          w = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
          for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
          mem_model[mem_addr_o] = w;
        end
      end
    end else begin
      mem_ready_i = 1'b0;
      stall = 1'b0;
    end
    #1;
    if (rsp_ready_o && rst_i) begin
      rsp_cnt++;
      check_true("rsp_expected", exp_rsp.size() != 0);
      if (exp_rsp.size() != 0) begin
        mon_r = exp_rsp.pop_front();
        check32("rsp_rdata", rsp_rdata_o, mon_r.rdata);
        if (mon_r.cyc >= 0) check32("rsp_cycle", cyc, mon_r.cyc);
        if (mon_r.byp) check32("rsp_with_mem_ready", {31'b0, mem_ready_i}, 32'd1);
      end
    end
  end

  task automatic exp_b(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    beat_t b;
    b.addr = addr; b.wdata = wdata; b.wstrb = wstrb;
    exp_beat.push_back(b);
  endtask

  task automatic issue(input bit fence, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rd, input int lat, input bit byp);
    rsp_t e;
    @(posedge clk_i); #2;
    e.rdata = exp_rd;
    e.cyc   = (lat >= 0) ? cyc + lat : -1;
    e.byp   = byp;
    exp_rsp.push_back(e);
    req_valid_i = 1'b1; req_fence_i = fence; req_addr_i = addr;
    req_wdata_i = wdata; req_wstrb_i = wstrb;
    @(posedge clk_i); #2;
    req_valid_i = 1'b0; req_fence_i = 1'b0; req_wstrb_i = '0;
  endtask

  task automatic do_req(input bit fence, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rd, input int lat, input bit byp);
    int r0;
    r0 = rsp_cnt;
    issue(fence, addr, wdata, wstrb, exp_rd, lat, byp);
    for (int i = 0; i < 400 && rsp_cnt == r0; i++) @(posedge clk_i);
    check_true("rsp_timeout", rsp_cnt != r0);
    check32("beats_left", exp_beat.size(), 0);
  endtask

  int mv0, b0;

  initial begin
    mem_model[32'h100]  = 32'h1111_1111;
    mem_model[32'h104]  = 32'h2222_2222;
    mem_model[32'h120]  = 32'h3333_3333;
    mem_model[32'h124]  = 32'h4444_4444;
    mem_model[32'h2000] = 32'h5A5A_0001;
    mem_model[32'h108]  = 32'h6666_6666;
    mem_model[32'h10C]  = 32'h7777_7777;
    mem_model[32'h140]  = 32'h8888_8888;
    mem_model[32'h144]  = 32'h9999_9999;

    #1 rst_i = 1'b0;
    #2;
    check32("rst_rsp_ready", {31'b0, rsp_ready_o}, 32'd0);
    check32("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check32("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    check32("rst_mem_addr", mem_addr_o, 32'h0);
    check32("rst_mem_wdata", mem_wdata_o, 32'h0);
    check32("rst_mem_wstrb", {28'b0, mem_wstrb_o}, 32'h0);
    check32("rst_mem_fence", {31'b0, mem_fence_o}, 32'd0);
    check32("rst_mem_instr", {31'b0, mem_instr_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;

    // Cold load fills two beats
    exp_b(32'h100, 32'h0, 4'h0);
    exp_b(32'h104, 32'h0, 4'h0);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 32'h1111_1111, -1, 1'b0);

    // Hit load, hit store, hit load: T+1, no memory traffic
    mv0 = mv_cnt;
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h2222_2222, 1, 1'b0);
    do_req(1'b0, 32'h104, 32'hAAAA_5555, 4'h3, 32'h2222_5555, 1, 1'b0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h2222_5555, 1, 1'b0);
    check32("hit_no_mem", mv_cnt - mv0, 0);
    repeat (2) @(posedge clk_i);
    #2;
    check32("rdata_hold", rsp_rdata_o, 32'h2222_5555);
    check32("rsp_idle_low", {31'b0, rsp_ready_o}, 32'd0);

    // Conflict miss evicts the dirty line then fills
    exp_b(32'h100, 32'h1111_1111, 4'hF);
    exp_b(32'h104, 32'h2222_5555, 4'hF);
    exp_b(32'h120, 32'h0, 4'h0);
    exp_b(32'h124, 32'h0, 4'h0);
    do_req(1'b0, 32'h120, 32'h0, 4'h0, 32'h3333_3333, -1, 1'b0);
    check32("wb_model_104", mem_model[32'h104], 32'h2222_5555);

    // Bypass load and store outside the cached window
    exp_b(32'h2000, 32'h0, 4'h0);
    do_req(1'b0, 32'h2000, 32'h0, 4'h0, 32'h5A5A_0001, -1, 1'b1);
    exp_b(32'h2004, 32'hDEAD_BEEF, 4'h4);
    do_req(1'b0, 32'h2004, 32'hDEAD_BEEF, 4'h4, 32'h0, -1, 1'b1);

    // Store miss into set 1 leaves a dirty line
    exp_b(32'h108, 32'h0, 4'h0);
    exp_b(32'h10C, 32'h0, 4'h0);
    do_req(1'b0, 32'h108, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, -1, 1'b0);

    // Fence writes back exactly the dirty line
    b0 = beat_cnt;
    exp_b(32'h108, 32'hCAFE_F00D, 4'hF);
    exp_b(32'h10C, 32'h7777_7777, 4'hF);
    do_req(1'b1, 32'h0, 32'h0, 4'h0, 32'h0, -1, 1'b0);
    check32("fence_beats", beat_cnt - b0, 2);

    // Clean fence: 2**DEPTH+1 cycles, no traffic; line stays valid
    mv0 = mv_cnt;
    do_req(1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 5, 1'b0);
    check32("fence2_no_mem", mv_cnt - mv0, 0);
    do_req(1'b0, 32'h108, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 1'b0);

    // Reset in the middle of a fill
    exp_b(32'h140, 32'h0, 4'h0);
    exp_b(32'h144, 32'h0, 4'h0);
    b0 = beat_cnt;
    issue(1'b0, 32'h140, 32'h0, 4'h0, 32'h8888_8888, -1, 1'b0);
    for (int i = 0; i < 100 && beat_cnt == b0; i++) @(posedge clk_i);
    check_true("first_beat_timeout", beat_cnt != b0);
    #2;
    check32("mid_fill_valid", {31'b0, mem_valid_o}, 32'd1);
    check32("mid_fill_addr", mem_addr_o, 32'h144);
    rst_i = 1'b0;
    #1;
    check32("rst_abort_valid", {31'b0, mem_valid_o}, 32'd0);
    check32("rst_abort_addr", mem_addr_o, 32'h0);
    exp_rsp.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;

    exp_b(32'h140, 32'h0, 4'h0);
    exp_b(32'h144, 32'h0, 4'h0);
    do_req(1'b0, 32'h140, 32'h0, 4'h0, 32'h8888_8888, -1, 1'b0);
    exp_b(32'h100, 32'h0, 4'h0);
    exp_b(32'h104, 32'h0, 4'h0);
    do_req(1'b0, 32'h104, 32'h0, 4'h0, 32'h2222_5555, -1, 1'b0);

    check32("rsp_left", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
